// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM state encoding and owner-index width for the display arbiter
package disp_pkg;
  localparam int OW = 3;
  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;
endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search from (i_ptr+1) mod N -> o_pick one-hot, o_idx, o_valid
module rr_pick
  import disp_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [OW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic [OW-1:0] o_idx,
  output logic          o_valid
);
  always_comb begin
    o_idx = '0;
    o_valid = 1'b0;
    o_pick = '0;
    for (int i = N; i >= 1; i--) begin
      if (i_req[(int'(i_ptr) + i) % N]) begin
        o_idx = OW'((int'(i_ptr) + i) % N);
        o_valid = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) o_pick[j] = o_valid && (o_idx == OW'(j));
  end
endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin owner of one multi7 display (i_req/i_values in, o_grant/o_owner/o_digits/o_blank out) with minimum dwell
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REQUESTERS   = 3,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [REQUESTERS-1:0]          i_req,
  input  logic [REQUESTERS*DIGITS*4-1:0] i_values,
  output logic [REQUESTERS-1:0]          o_grant,
  output logic [DIGITS*4-1:0]            o_digits,
  output logic                           o_blank,
  output logic [OW-1:0]                  o_owner
);
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam int DW = DIGITS * 4;
  state_t                r_state, w_nxt_state;
  logic [REQUESTERS-1:0] r_grant, w_nxt_grant, w_pick;
  logic [OW-1:0]         r_owner, r_ptr, w_idx, w_nxt_owner, w_nxt_ptr;
  logic [CW-1:0]         r_cnt, w_nxt_cnt;
  logic [DW-1:0]         r_digits, w_nxt_digits;
  logic                  r_blank, w_valid, w_sat, w_drop, w_switch;

  rr_pick #(.N(REQUESTERS)) u_rr (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr <= OW'(REQUESTERS - 1);
      r_cnt <= '0;
      r_digits <= '0;
      r_blank <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_grant <= w_nxt_grant;
      r_owner <= w_nxt_owner;
      r_ptr <= w_nxt_ptr;
      r_cnt <= w_nxt_cnt;
      r_digits <= w_nxt_digits;
      r_blank <= w_nxt_state == IDLE;
    end
  end

  // a drop (owner no longer requesting, always true in IDLE) or an expired dwell reopens arbitration
  always_comb begin
    w_sat = r_cnt == CW'(DWELL_CYCLES - 1);
    w_drop = !(|(i_req & r_grant));
    w_switch = w_drop || w_sat;
    w_nxt_state = w_switch ? (w_valid ? SHOW : IDLE) : r_state;
  end

  // search ends on the owner itself, so an expired owner with no rivals re-picks itself and keeps its saturated count
  always_comb begin
    w_nxt_grant = w_switch ? w_pick : r_grant;
    w_nxt_owner = w_switch ? w_idx : r_owner;
    w_nxt_ptr = (w_switch && w_valid) ? w_idx : r_ptr;
    w_nxt_cnt = !w_switch ? r_cnt + 1'b1 : (!w_drop && w_idx == r_owner) ? r_cnt : '0;
    w_nxt_digits = '0;
    for (int k = 0; k < REQUESTERS; k++)
      if (w_nxt_state == SHOW && w_nxt_owner == OW'(k)) w_nxt_digits = i_values[k*DW +: DW];
  end

  assign o_grant = r_grant;
  assign o_owner = r_owner;
  assign o_digits = r_digits;
  assign o_blank = r_blank;
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed stimulus, cycle-level reference model and literal checks for disp_arbiter
module tb_disp_arbiter;
  localparam int R = 3;
  localparam int D = 4;
  localparam int DG = 4;
  logic i_clk, i_rst;
  logic [R-1:0] i_req;
  logic [R*DG*4-1:0] i_values;
  logic [R-1:0] o_grant;
  logic [DG*4-1:0] o_digits;
  logic o_blank;
  logic [2:0] o_owner;
  int tests = 0, failed = 0;
  int m_owner, m_ptr, m_age, n;
  logic [15:0] m_dig;

  disp_arbiter #(.DIGITS(DG), .REQUESTERS(R), .DWELL_CYCLES(D)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_values(i_values),
    .o_grant(o_grant), .o_digits(o_digits), .o_blank(o_blank), .o_owner(o_owner)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [R-1:0] req, input int ptr);
    for (int off = 1; off <= R; off++)
      if (req[(ptr + off) % R]) return (ptr + off) % R;
    return -1;
  endfunction

  // model: owner (-1 idle) plus cycles already shown; a rival may take over once age reaches D
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_owner = -1; m_ptr = R - 1; m_age = 0; m_dig = 0;
    end else begin
      if (m_owner < 0 || !i_req[m_owner] || m_age >= D) begin
        n = rr(i_req, m_ptr);
        if (n < 0) m_owner = -1;
        else if (n == m_owner) m_age++;
        else begin m_owner = n; m_ptr = n; m_age = 1; end
      end else m_age++;
      m_dig = m_owner < 0 ? 16'h0 : i_values[m_owner*16 +: 16];
    end
  end

  always @(negedge i_clk) begin
    chk("grant", o_grant, m_owner < 0 ? 0 : (1 << m_owner));
    chk("owner", o_owner, m_owner < 0 ? 0 : m_owner);
    chk("digits", o_digits, m_dig);
    chk("blank", o_blank, m_owner < 0);
    chk("blank_inv", o_blank, ~|o_grant);
  end

  task automatic cyc(input logic [R-1:0] req);
    i_req = req;
    @(posedge i_clk);
    #2;
  endtask

  task automatic rst_pulse;
    i_rst = 1;
    cyc(i_req);
    i_rst = 0;
  endtask

  initial begin
    i_rst = 1; i_req = 0;
    i_values = {16'hC0DE, 16'h5947, 16'h0AAA};
    cyc(0); cyc(0);
    i_rst = 0;
    for (int i = 0; i < 10; i++) cyc(3'b000);
    chk("idle_blank", o_blank, 1);
    chk("idle_grant", o_grant, 3'b000);
    chk("idle_digits", o_digits, 16'h0000);
    cyc(3'b010);
    chk("g1_grant", o_grant, 3'b010);
    chk("g1_owner", o_owner, 1);
    chk("g1_digits", o_digits, 16'h5947);
    i_values[31:16] = 16'h1234;
    cyc(3'b010);
    chk("g1_live", o_digits, 16'h1234);
    cyc(3'b000);
    chk("g1_release", o_blank, 1);
    rst_pulse();
    i_req = 3'b111;
    for (int i = 0; i < 16; i++) begin
      cyc(3'b111);
      chk("rr_seq", o_grant, (i / 4) % 3 == 0 ? 3'b001 : (i / 4) % 3 == 1 ? 3'b010 : 3'b100);
    end
    cyc(3'b000);
    rst_pulse();
    for (int i = 0; i < 10; i++) cyc(3'b001);
    chk("hold_only", o_grant, 3'b001);
    cyc(3'b011);
    chk("hold_switch", o_grant, 3'b010);
    cyc(3'b000);
    rst_pulse();
    cyc(3'b100);
    cyc(3'b100);
    chk("drop_pre", o_grant, 3'b100);
    cyc(3'b001);
    chk("drop_regrant", o_grant, 3'b001);
    chk("drop_digits", o_digits, 16'h0AAA);
    cyc(3'b100);
    cyc(3'b100);
    chk("drop2_pre", o_grant, 3'b100);
    cyc(3'b000);
    chk("drop_idle", o_blank, 1);
    rst_pulse();
    cyc(3'b111); cyc(3'b111); cyc(3'b111);
    chk("mid_show", o_grant, 3'b001);
    #1 i_rst = 1;
    #1;
    chk("async_grant", o_grant, 3'b000);
    chk("async_blank", o_blank, 1);
    chk("async_digits", o_digits, 16'h0000);
    cyc(3'b111);
    i_rst = 0;
    cyc(3'b111);
    chk("post_rst", o_grant, 3'b001);
    cyc(3'b000);
    cyc(3'b000);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter DIGITS, default 4, number of hex digits per displayed value; matches the multi7 DIGITS it feeds.
REQ-002 Parameter REQUESTERS, default 3, number of requesters sharing one multi7 display (range 2..8).
REQ-003 Parameter DWELL_CYCLES, default 50_000_000, minimum i_clk cycles a granted value stays on the display while others wait.
REQ-004 Port i_clk, input, 1, the single clock.
REQ-005 Port i_rst, input, 1; reset is asynchronous and active-high.
REQ-006 Port i_req, input, REQUESTERS, per-requester display request, level-sensitive.
REQ-007 Port i_values, input, REQUESTERS*DIGITS*4, packed hex values; requester k occupies bits [k*DIGITS*4 +: DIGITS*4].
REQ-008 Port o_grant, output, REQUESTERS, one-hot (or zero) current owner of the display.
REQ-009 Port o_digits, output, DIGITS*4, value driven to multi7 i_digits.
REQ-010 Port o_blank, output, 1, high when no requester owns the display.
REQ-011 Port o_owner, output, 3, binary index of the granted requester; 0 when idle.

Function
REQ-012 Two-state FSM: IDLE, SHOW; every output is registered.
REQ-013 IDLE: o_grant=0, o_blank=1, o_digits=0, o_owner=0.
REQ-014 IDLE with any i_req bit high in cycle N: round-robin pick; SHOW, o_grant, o_owner and o_digits valid in cycle N+1.
REQ-015 Round-robin search starts at (last owner + 1) mod REQUESTERS, wraps, returns the first set i_req bit.
REQ-016 Last-owner pointer updates only on a grant; reset value REQUESTERS-1, so requester 0 wins the first contention.
REQ-017 SHOW: o_digits re-registers the owner's i_values slice every cycle (1-cycle latency, live updates).
REQ-018 SHOW: dwell counter increments each cycle from 0, saturates at DWELL_CYCLES-1; width = clog2(DWELL_CYCLES).
REQ-019 Counter at DWELL_CYCLES-1 with another requester pending: grant moves to the round-robin pick next cycle; counter returns to 0.
REQ-020 Counter at DWELL_CYCLES-1 with only the owner requesting: owner retained; counter holds at DWELL_CYCLES-1, so a later request switches the grant on the cycle after it appears.
REQ-021 Owner drops i_req at any count: released next cycle; other requests pending -> immediate re-grant via REQ-015 with counter 0; none pending -> IDLE.
REQ-022 Drop and dwell expiry in the same cycle: handled as drop (REQ-021).
REQ-023 o_grant never has more than one bit set; o_grant changes only at a clock edge.
REQ-024 o_blank equals the inverse of OR(o_grant) at every cycle.

Reset
REQ-025 i_rst high asynchronously forces IDLE, counter 0, pointer REQUESTERS-1 and all outputs to the REQ-013 values, including mid-SHOW.
REQ-026 After i_rst deasserts, the first arbitration occurs on the first rising i_clk edge with i_rst low.

Structure
REQ-027 Shared package disp_pkg holds the FSM state encodings (IDLE=0, SHOW=1) and the owner-index width constant (3).
REQ-028 The round-robin search is one combinational sub-module, rr_pick (inputs: request vector, pointer; outputs: one-hot pick, index, any-valid).
REQ-029 The multi7 instance is outside this block; top connects o_digits to i_digits and gates display enables with o_blank.

Verification (DWELL_CYCLES=4, REQUESTERS=3, DIGITS=4)
REQ-030 Reset, i_req=000 -> o_blank=1, o_grant=000, o_digits=0000 for 10 cycles.
REQ-031 i_req=010 at cycle N, value[1]=h5947 -> cycle N+1: o_grant=010, o_owner=1, o_digits=h5947; value[1] changed to h1234 -> o_digits=h1234 one cycle later.
REQ-032 i_req=111 held from reset -> grants 001,010,100,001 each lasting exactly 4 cycles.
REQ-033 Owner 0 granted, i_req=001 for 10 cycles, then i_req=011 -> grant stays 001, moves to 010 the cycle after bit 1 rises.
REQ-034 Owner 2 drops i_req at count 1 with i_req[0] high -> next cycle o_grant=001, counter 0; with no others -> IDLE, o_blank=1.
REQ-035 i_rst pulsed for 1 cycle mid-SHOW at count 2 -> outputs idle immediately (before next edge); first grant after release goes to requester 0 under i_req=111.
